// File: rtl/phase_seq_pkg.sv
// Shared definitions for the phase sequencer: phase bit positions,
// FSM state codes and the state-to-phase mapping.
package phase_seq_pkg;

    // Bit positions inside the one-hot phase vector {w,m,x,r,f}
    localparam int PH_F = 0;
    localparam int PH_R = 1;
    localparam int PH_X = 2;
    localparam int PH_M = 3;
    localparam int PH_W = 4;
    localparam int PH_N = 5;

    typedef logic [2:0] state_t;

    // FSM state codes. F..W are contiguous so "running" is a range check.
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_F     = 3'd1;
    localparam logic [2:0] ST_R     = 3'd2;
    localparam logic [2:0] ST_X     = 3'd3;
    localparam logic [2:0] ST_M     = 3'd4;
    localparam logic [2:0] ST_W     = 3'd5;
    localparam logic [2:0] ST_HALT  = 3'd6;
    localparam logic [2:0] ST_FAULT = 3'd7;

    // The state that lights a given phase bit.
    function automatic state_t phase_state(input int idx);
        state_t st;
        st = ST_IDLE;
        case (idx)
            PH_F:    st = ST_F;
            PH_R:    st = ST_R;
            PH_X:    st = ST_X;
            PH_M:    st = ST_M;
            PH_W:    st = ST_W;
            default: st = ST_IDLE;
        endcase
        return st;
    endfunction

endpackage

// File: rtl/phase_seq_if.sv
// Control/status bundle between the phase sequencer and the rest of the core.
interface phase_seq_if #(
    parameter int CNT_W = 32
);
    // Core -> sequencer
    logic             start;
    logic             stop_req;
    logic             imem_ack;
    logic             dmem_ack;
    logic             is_mem;
    logic             is_halt;

    // Sequencer -> core
    logic [4:0]       phase;
    logic             ir_load;
    logic             dmem_req;
    logic             running;
    logic             halted;
    logic             fault;
    logic [CNT_W-1:0] inst_count;
    logic [CNT_W-1:0] cycle_count;

    // Driver side (core / bench)
    modport master (
        output start, stop_req, imem_ack, dmem_ack, is_mem, is_halt,
        input  phase, ir_load, dmem_req, running, halted, fault,
        input  inst_count, cycle_count
    );

    // Sequencer side
    modport slave (
        input  start, stop_req, imem_ack, dmem_ack, is_mem, is_halt,
        output phase, ir_load, dmem_req, running, halted, fault,
        output inst_count, cycle_count
    );

endinterface

// File: rtl/phase_seq_wait_timer.sv
// Ack watchdog shared by the R and M wait states. Counts consecutive
// non-ack cycles; o_expired flags the cycle that would be the TMO-th
// such cycle, so the FSM can let a same-cycle ack win over the fault.
module phase_seq_wait_timer #(
    parameter int TMO   = 16,
    parameter int TMO_W = 5
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clear,
    input  logic i_en,
    output logic o_expired
);

    logic [TMO_W-1:0] r_count;

    // Clear has priority: a fresh wait state always starts from zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_en && !o_expired) begin
            r_count <= r_count + TMO_W'(1);
        end
    end

    // Count value k means k non-ack cycles already elapsed in this state.
    assign o_expired = (r_count == TMO_W'(TMO - 1));

endmodule

// File: rtl/phase_seq.sv
// One-hot phase sequencer for the multi-cycle core. Walks F,R,X,(M),W,
// inserts imem/dmem wait states, handles halt/stop/start and the ack
// watchdog, and keeps retired-instruction and active-cycle counters.
module phase_seq
    import phase_seq_pkg::*;
#(
    parameter int CNT_W = 32,
    parameter int TMO   = 16,
    parameter int TMO_W = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    phase_seq_if.slave bus
);

    state_t           r_state;
    state_t           w_next;
    logic             r_is_mem_q;
    logic             r_halt_q;
    logic [CNT_W-1:0] r_inst_count;
    logic [CNT_W-1:0] r_cycle_count;

    logic [PH_N-1:0]  w_phase;
    logic             w_running;
    logic             w_expired;
    logic             w_clear;
    logic             w_en;

    // Next-state logic; HALT and FAULT hold until reset.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (bus.start) w_next = ST_F;
            end
            ST_F: begin
                // pc advances on every f cycle, so F never repeats
                w_next = ST_R;
            end
            ST_R: begin
                if (bus.imem_ack)  w_next = ST_X;
                else if (w_expired) w_next = ST_FAULT;
            end
            ST_X: begin
                w_next = bus.is_mem ? ST_M : ST_W;
            end
            ST_M: begin
                if (bus.dmem_ack)  w_next = ST_W;
                else if (w_expired) w_next = ST_FAULT;
            end
            ST_W: begin
                // halt outranks stop; stop_req is only looked at here
                if (r_halt_q)          w_next = ST_HALT;
                else if (bus.stop_req) w_next = ST_IDLE;
                else                   w_next = ST_F;
            end
            default: begin
                w_next = r_state;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Capture the decoded op attributes while they are valid in x.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_is_mem_q <= 1'b0;
            r_halt_q   <= 1'b0;
        end else if (r_state == ST_X) begin
            r_is_mem_q <= bus.is_mem;
            r_halt_q   <= bus.is_halt;
        end
    end

    // Retired-instruction and active-cycle counters, both wrap freely.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_inst_count  <= '0;
            r_cycle_count <= '0;
        end else begin
            if (r_state == ST_W) r_inst_count  <= r_inst_count + CNT_W'(1);
            if (w_running)       r_cycle_count <= r_cycle_count + CNT_W'(1);
        end
    end

    // Watchdog restarts on every entry into a wait state and counts
    // only the cycles where the awaited ack is missing.
    assign w_clear = ((w_next == ST_R) && (r_state != ST_R)) ||
                     ((w_next == ST_M) && (r_state != ST_M));
    assign w_en    = ((r_state == ST_R) && !bus.imem_ack) ||
                     ((r_state == ST_M) && !bus.dmem_ack);

    phase_seq_wait_timer #(
        .TMO   (TMO),
        .TMO_W (TMO_W)
    ) u_wait_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_clear   (w_clear),
        .i_en      (w_en),
        .o_expired (w_expired)
    );

    // One-hot phase is a straight decode of the registered state.
    for (genvar gi = 0; gi < PH_N; gi++) begin : g_phase
        assign w_phase[gi] = (r_state == phase_state(gi));
    end

    assign w_running       = |w_phase;

    assign bus.phase       = w_phase;
    assign bus.running     = w_running;
    assign bus.halted      = (r_state == ST_HALT);
    assign bus.fault       = (r_state == ST_FAULT);
    assign bus.ir_load     = w_phase[PH_R] & bus.imem_ack;
    // M is only ever entered for a memory op, so the qualifier never
    // trims a real request; it keeps the request tied to the captured op.
    assign bus.dmem_req    = w_phase[PH_M] & r_is_mem_q;
    assign bus.inst_count  = r_inst_count;
    assign bus.cycle_count = r_cycle_count;

endmodule

// File: tb/tb_phase_seq.sv
// Directed bench for phase_seq: each cycle is labelled with the state the
// sequencer must show; the expected outputs for that label are queued
// and a separate monitor compares them on the falling edge.
module tb_phase_seq;
    import phase_seq_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    phase_seq_if #(.CNT_W(32)) bus ();

    phase_seq #(
        .CNT_W (32),
        .TMO   (16),
        .TMO_W (5)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        byte         st;
        logic [4:0]  phase;
        logic        run;
        logic        hlt;
        logic        flt;
        logic        dreq;
        logic        irl;
        logic [31:0] inst;
        logic [31:0] cyc;
    } exp_t;

    exp_t sb_q[$];

    int n_vec  = 0;
    int n_miss = 0;

    // Input values to apply on the next cycle
    logic p_rst = 1'b0, p_start = 1'b0, p_stop = 1'b0;
    logic p_iack = 1'b0, p_dack = 1'b0, p_mem = 1'b0, p_halt = 1'b0;

    // Expected counter values visible in the current cycle
    logic [31:0] m_inst = '0;
    logic [31:0] m_cyc  = '0;

    initial begin
        bus.start = 1'b0; bus.stop_req = 1'b0; bus.imem_ack = 1'b0;
        bus.dmem_ack = 1'b0; bus.is_mem = 1'b0; bus.is_halt = 1'b0;
    end

    // One cycle: apply pending inputs just after the edge and queue what
    // the outputs must look like for the labelled state.
    task automatic cyc(input byte st);
        exp_t e;
        @(posedge clk);
        #1;
        rst_n        = p_rst;
        bus.start    = p_start;
        bus.stop_req = p_stop;
        bus.imem_ack = p_iack;
        bus.dmem_ack = p_dack;
        bus.is_mem   = p_mem;
        bus.is_halt  = p_halt;
        e.st    = st;
        e.phase = 5'b00000;
        case (st)
            "F":     e.phase = 5'b00001;
            "R":     e.phase = 5'b00010;
            "X":     e.phase = 5'b00100;
            "M":     e.phase = 5'b01000;
            "W":     e.phase = 5'b10000;
            default: e.phase = 5'b00000;
        endcase
        e.run  = (e.phase != 5'b00000);
        e.hlt  = (st == "H");
        e.flt  = (st == "T");
        e.dreq = (st == "M");
        e.irl  = (st == "R") && p_iack;
        if (!p_rst) begin
            m_inst = '0;
            m_cyc  = '0;
        end
        e.inst = m_inst;
        e.cyc  = m_cyc;
        sb_q.push_back(e);
        if (p_rst) begin
            if (e.run) m_cyc = m_cyc + 32'd1;
            if (st == "W") m_inst = m_inst + 32'd1;
        end
    endtask

    // Monitor: pop and compare on every falling edge with work queued.
    exp_t mon_e;
    bit   mon_bad;
    initial begin
        forever begin
            @(negedge clk);
            if (sb_q.size() != 0) begin
                mon_e   = sb_q.pop_front();
                mon_bad = 1'b0;
                n_vec++;
                if (bus.phase !== mon_e.phase) begin
                    $display("FAIL phase vec %0d (%c): got %b want %b", n_vec, mon_e.st, bus.phase, mon_e.phase);
                    mon_bad = 1'b1;
                end
                if ({bus.running, bus.halted, bus.fault} !== {mon_e.run, mon_e.hlt, mon_e.flt}) begin
                    $display("FAIL flags vec %0d (%c): got run/hlt/flt %b%b%b want %b%b%b", n_vec, mon_e.st,
                             bus.running, bus.halted, bus.fault, mon_e.run, mon_e.hlt, mon_e.flt);
                    mon_bad = 1'b1;
                end
                if ({bus.dmem_req, bus.ir_load} !== {mon_e.dreq, mon_e.irl}) begin
                    $display("FAIL req vec %0d (%c): got dmem_req/ir_load %b%b want %b%b", n_vec, mon_e.st,
                             bus.dmem_req, bus.ir_load, mon_e.dreq, mon_e.irl);
                    mon_bad = 1'b1;
                end
                if (bus.inst_count !== mon_e.inst) begin
                    $display("FAIL inst_count vec %0d (%c): got %0d want %0d", n_vec, mon_e.st, bus.inst_count, mon_e.inst);
                    mon_bad = 1'b1;
                end
                if (bus.cycle_count !== mon_e.cyc) begin
                    $display("FAIL cycle_count vec %0d (%c): got %0d want %0d", n_vec, mon_e.st, bus.cycle_count, mon_e.cyc);
                    mon_bad = 1'b1;
                end
                if (mon_bad) n_miss++;
                else $display("vec %0d %c ok phase=%b inst=%0d cyc=%0d", n_vec, mon_e.st, bus.phase, bus.inst_count, bus.cycle_count);
            end
        end
    end

    initial begin
        // Reset held, then released with no start
        cyc("I"); cyc("I");
        p_rst = 1'b1; cyc("I"); cyc("I");

        // Zero-wait non-memory ops: 4-cycle period
        p_start = 1'b1; cyc("I"); p_start = 1'b0;
        p_iack = 1'b1;
        repeat (3) begin cyc("F"); cyc("R"); cyc("X"); cyc("W"); end

        // imem_ack late by 2 cycles: r held 3 cycles, f only once
        cyc("F"); p_iack = 1'b0; cyc("R"); cyc("R"); p_iack = 1'b1; cyc("R"); cyc("X"); cyc("W");

        // Memory op with dmem_ack on the 3rd M cycle
        cyc("F"); cyc("R"); p_mem = 1'b1; cyc("X"); p_mem = 1'b0;
        cyc("M"); cyc("M"); p_dack = 1'b1; cyc("M"); p_dack = 1'b0; cyc("W");

        // stop_req outside W ignored; stop_req in W returns to IDLE
        p_stop = 1'b1; cyc("F"); cyc("R"); cyc("X"); p_stop = 1'b0; cyc("W");
        cyc("F"); cyc("R"); cyc("X"); p_stop = 1'b1; cyc("W"); p_stop = 1'b0;
        cyc("I"); cyc("I");

        // Ack on the 16th R cycle wins; then no ack at all -> FAULT
        p_start = 1'b1; cyc("I"); p_start = 1'b0;
        cyc("F"); p_iack = 1'b0; repeat (15) cyc("R"); p_iack = 1'b1; cyc("R"); cyc("X"); cyc("W");
        cyc("F"); p_iack = 1'b0; repeat (16) cyc("R"); cyc("T");
        p_start = 1'b1; p_dack = 1'b1; repeat (3) cyc("T"); p_start = 1'b0; p_dack = 1'b0;
        p_rst = 1'b0; cyc("I"); p_rst = 1'b1; cyc("I");

        // dmem watchdog in M
        p_start = 1'b1; cyc("I"); p_start = 1'b0; p_iack = 1'b1;
        cyc("F"); cyc("R"); p_mem = 1'b1; cyc("X"); p_mem = 1'b0;
        repeat (16) cyc("M"); cyc("T");
        p_rst = 1'b0; cyc("I"); p_rst = 1'b1; cyc("I");

        // Halt with stop_req in the same W: halt wins, start ignored
        p_start = 1'b1; cyc("I"); p_start = 1'b0;
        cyc("F"); cyc("R"); p_halt = 1'b1; cyc("X"); p_halt = 1'b0; p_stop = 1'b1; cyc("W"); p_stop = 1'b0;
        cyc("H"); p_start = 1'b1; cyc("H"); cyc("H"); p_start = 1'b0;
        p_rst = 1'b0; cyc("I"); p_rst = 1'b1; cyc("I");

        // Reset in the middle of M, then restart from F
        p_start = 1'b1; cyc("I"); p_start = 1'b0;
        cyc("F"); cyc("R"); cyc("X"); cyc("W");
        cyc("F"); cyc("R"); p_mem = 1'b1; cyc("X"); p_mem = 1'b0; cyc("M");
        p_rst = 1'b0; p_dack = 1'b1; cyc("I"); p_rst = 1'b1; p_dack = 1'b0;
        cyc("I");
        p_start = 1'b1; cyc("I"); p_start = 1'b0;
        cyc("F"); cyc("R"); cyc("X"); cyc("W"); cyc("F");

        // Let the monitor drain the queue, bounded
        repeat (4) @(negedge clk);
        #2;
        if (sb_q.size() != 0) begin
            $display("FAIL drain: %0d entries left, want 0", sb_q.size());
            n_miss++;
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
